magnetron_ctrl: RTL and testbench

Cook-cycle sequencer for the magnetron. It takes the front-panel start and stop/clear pulses, the door interlock and a programmed cook time, and drives the magnetron enable for exactly the programmed number of seconds. Cooking pauses whenever the door opens. The block sits between the panel/keypad logic and the magnetron driver. It is fully synchronous and replaces ad-hoc latch-based enable holding.

---
 rtl/magnetron_ctrl_pkg.sv | 20 ++
 rtl/magnetron_ctrl_cook_timer.sv | 46 ++++
 rtl/magnetron_ctrl.sv | 101 ++++++++++
 tb/tb_magnetron_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/magnetron_ctrl_pkg.sv
// Shared definitions for the magnetron cook-cycle sequencer: state
// encodings, default sizing and a prescaler width helper.
package magnetron_ctrl_pkg;

    localparam int TICK_DIV_DEF = 50_000_000;
    localparam int TIME_W_DEF   = 12;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_COOK  = 2'd1,
        MC_PAUSE = 2'd2,
        MC_DONE  = 2'd3
    } mc_state_t;

    // At least one bit, even for the smallest legal divider.
    function automatic int presc_width(input int div);
        return ($clog2(div) < 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/magnetron_ctrl_cook_timer.sv
// One-second prescaler plus the seconds-remaining down-counter.
// The FSM steers it with load/run/clear; it never wraps below zero.
module cook_timer
    import magnetron_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int TIME_W   = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              run,
    input  logic              clear,
    output logic [TIME_W-1:0] remaining,
    output logic              last_tick
);

    localparam int              PW        = presc_width(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          wrap;

    assign wrap      = (presc == PRESC_MAX);
    assign last_tick = wrap && (remaining == TIME_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            remaining <= '0;
        end else begin
            // Prescaler only advances while running, so a pause keeps the partial second.
            if (clear)
                presc <= '0;
            else if (run)
                presc <= wrap ? '0 : presc + 1'b1;

            if (load)
                remaining <= load_val;
            else if (run && wrap && (remaining != '0))
                remaining <= remaining - 1'b1;
        end
    end

endmodule

// File: rtl/magnetron_ctrl.sv
// Cook-cycle sequencer: holds the magnetron enable for the programmed
// number of seconds, pausing on door open or stop, with a DONE hold state.
module magnetron_ctrl
    import magnetron_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int TIME_W   = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop_clear,
    input  logic              door_closed,
    input  logic              load_time,
    input  logic [TIME_W-1:0] set_time,
    output logic              mag_on,
    output logic              done,
    output logic [TIME_W-1:0] remaining,
    output logic [1:0]        state
);

    mc_state_t         state_q, state_n;
    logic              done_q;
    logic              tmr_load;
    logic [TIME_W-1:0] tmr_load_val;
    logic              tmr_run;
    logic              tmr_clear;
    logic              last_tick;

    cook_timer #(
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_val  (tmr_load_val),
        .run       (tmr_run),
        .clear     (tmr_clear),
        .remaining (remaining),
        .last_tick (last_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            done_q  <= (state_n == MC_DONE);
        end
    end

    // Event priority: stop_clear, then door open, then terminal tick, then start.
    always_comb begin
        state_n      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = set_time;
        tmr_run      = 1'b0;
        tmr_clear    = 1'b0;
        case (state_q)
            MC_IDLE: begin
                tmr_load = load_time;
                if (start && door_closed && (remaining != '0)) begin
                    state_n   = MC_COOK;
                    tmr_clear = 1'b1;
                end
            end
            MC_COOK: begin
                if (stop_clear || !door_closed) begin
                    state_n = MC_PAUSE;
                end else begin
                    tmr_run = 1'b1;
                    if (last_tick)
                        state_n = MC_DONE;
                end
            end
            MC_PAUSE: begin
                if (stop_clear) begin
                    state_n      = MC_IDLE;
                    tmr_load     = 1'b1;
                    tmr_load_val = '0;
                end else if (start && door_closed) begin
                    state_n = MC_COOK;
                end
            end
            MC_DONE: begin
                tmr_load = load_time;
                if (stop_clear || !door_closed || load_time)
                    state_n = MC_IDLE;
            end
            default: state_n = MC_IDLE;
        endcase
    end

    // Door term is deliberately combinational so an opening door cuts power at once.
    assign mag_on = (state_q == MC_COOK) && door_closed;
    assign done   = done_q;
    assign state  = state_q;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Directed bench for magnetron_ctrl (TICK_DIV=4, TIME_W=8): stimulus pushes
// hand-computed per-cycle expectations, a negedge monitor pops and compares.
module tb_magnetron_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop_clear, door_closed, load_time;
    logic [7:0] set_time;
    logic       mag_on, done;
    logic [7:0] remaining;
    logic [1:0] state;

    typedef struct {
        logic [1:0] st;
        logic       mag;
        logic       dn;
        logic [7:0] rem;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    magnetron_ctrl #(.TICK_DIV(4), .TIME_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_closed (door_closed),
        .load_time   (load_time),
        .set_time    (set_time),
        .mag_on      (mag_on),
        .done        (done),
        .remaining   (remaining),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({state, mag_on, done, remaining} !== {mon_e.st, mon_e.mag, mon_e.dn, mon_e.rem}) begin
                errors++;
                $display("FAIL %s: got state=%0d mag_on=%0b done=%0b remaining=%0d, want state=%0d mag_on=%0b done=%0b remaining=%0d",
                         mon_e.name, state, mag_on, done, remaining, mon_e.st, mon_e.mag, mon_e.dn, mon_e.rem);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start      = 1'b0;
        stop_clear = 1'b0;
        load_time  = 1'b0;
    endtask

    task automatic expect_now(input logic [1:0] es, input logic em, input logic ed,
                              input logic [7:0] er, input string nm);
        exp_t e;
        e.st = es; e.mag = em; e.dn = ed; e.rem = er; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic load(input logic [7:0] t);
        load_time = 1'b1;
        set_time  = t;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;
        load_time = 1'b0; set_time = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_now(2'd0, 1'b0, 1'b0, 8'd0, "reset");

        // Blocked starts: zero time, then door open
        start = 1'b1;
        tick();
        expect_now(2'd0, 1'b0, 1'b0, 8'd0, "blk_rem0");
        load(8'd5);
        expect_now(2'd0, 1'b0, 1'b0, 8'd5, "load_idle");
        door_closed = 1'b0;
        start = 1'b1;
        tick();
        expect_now(2'd0, 1'b0, 1'b0, 8'd5, "blk_door");
        door_closed = 1'b1;

        // Uninterrupted 3 s cook
        load(8'd3);
        start = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            expect_now(2'd1, 1'b1, 1'b0, 8'(3 - i / 4), "cook3");
            tick();
        end
        expect_now(2'd3, 1'b0, 1'b1, 8'd0, "cook3_done");
        start = 1'b1;
        tick();
        expect_now(2'd3, 1'b0, 1'b1, 8'd0, "done_start_ign");
        stop_clear = 1'b1;
        tick();
        expect_now(2'd0, 1'b0, 1'b0, 8'd0, "done_clear");

        // Door pause and resume
        load(8'd2);
        start = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            expect_now(2'd1, 1'b1, 1'b0, 8'(2 - i / 4), "cook2");
            tick();
        end
        door_closed = 1'b0;
        expect_now(2'd1, 1'b0, 1'b0, 8'd1, "door_drop");
        tick();
        load_time = 1'b1;
        set_time  = 8'd9;
        expect_now(2'd2, 1'b0, 1'b0, 8'd1, "pause_hold");
        tick();
        expect_now(2'd2, 1'b0, 1'b0, 8'd1, "pause_load_ign");
        door_closed = 1'b1;
        start = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            expect_now(2'd1, 1'b1, 1'b0, 8'd1, "resume");
            tick();
        end
        expect_now(2'd3, 1'b0, 1'b1, 8'd0, "resume_done");
        door_closed = 1'b0;
        tick();
        expect_now(2'd0, 1'b0, 1'b0, 8'd0, "done_door_exit");
        door_closed = 1'b1;

        // Stop, then stop+start together
        load(8'd5);
        start = 1'b1;
        tick();
        expect_now(2'd1, 1'b1, 1'b0, 8'd5, "cook5");
        tick();
        stop_clear = 1'b1;
        expect_now(2'd1, 1'b1, 1'b0, 8'd5, "cook5_stop");
        tick();
        expect_now(2'd2, 1'b0, 1'b0, 8'd5, "stop_pause");
        start = 1'b1;
        stop_clear = 1'b1;
        tick();
        expect_now(2'd0, 1'b0, 1'b0, 8'd0, "stop_wins");

        // Door open on the terminal-tick cycle
        load(8'd1);
        start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_now(2'd1, 1'b1, 1'b0, 8'd1, "cook1");
            tick();
        end
        door_closed = 1'b0;
        expect_now(2'd1, 1'b0, 1'b0, 8'd1, "term_drop");
        tick();
        expect_now(2'd2, 1'b0, 1'b0, 8'd1, "term_pause");
        door_closed = 1'b1;
        start = 1'b1;
        tick();
        expect_now(2'd1, 1'b1, 1'b0, 8'd1, "term_resume");
        tick();
        expect_now(2'd3, 1'b0, 1'b1, 8'd0, "term_done");
        load_time = 1'b1;
        set_time  = 8'd4;
        tick();
        expect_now(2'd0, 1'b0, 1'b0, 8'd4, "done_load");

        // Reset mid-cook
        start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_now(2'd1, 1'b1, 1'b0, 8'd4, "cook4");
            tick();
        end
        rst = 1'b1;
        tick();
        expect_now(2'd0, 1'b0, 1'b0, 8'd0, "rst_mid");
        rst = 1'b0;
        tick();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
